// File: rtl/wb_button_initiator.sv
// Wishbone classic initiator: debounced push-buttons step an 8-bit LED pattern, each press writes it to TARGET_ADR.
// Optional read-back of the written word after every successful write: define WB_INITIATOR_READBACK_EN.
module wb_button_initiator #(
    parameter logic [31:0] TARGET_ADR      = 32'h3000_0000,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic [2:0]  buttons,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        err,
    output logic [31:0] rd_data,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer completes on a rising edge where cyc=stb=1 and ack=1; stb is held until then or until timeout.
`ifdef WB_INITIATOR_READBACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1} state_t;
`endif

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  sync1, sync2, level, press, pending, pend_clr;
    logic [15:0] db_cnt [3];

    state_t      state, state_d;
    logic        cyc_d, stb_d, we_d, err_d;
    logic [3:0]  sel_d;
    logic [31:0] adr_d, dat_d;
    logic [7:0]  pat, pat_d, pat_nxt, pat_nxt_d;
    logic [15:0] tmo_cnt, tmo_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    // A level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreeing sample restarts the count.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            level <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++)
            press[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) pending <= '0;
        else           pending <= (pending & ~pend_clr) | press;
    end

`ifdef WB_INITIATOR_READBACK_EN
    logic [31:0] rd_q, rd_d;
    assign rd_data = rd_q;
`else
    logic unused_dat_i;
    assign unused_dat_i = ^wbm_dat_i;
    assign rd_data      = '0;
`endif

    always_comb begin
        state_d   = state;
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        we_d      = 1'b0;
        sel_d     = '0;
        adr_d     = '0;
        dat_d     = '0;
        pat_d     = pat;
        pat_nxt_d = pat_nxt;
        tmo_d     = '0;
        err_d     = err;
        pend_clr  = '0;
`ifdef WB_INITIATOR_READBACK_EN
        rd_d      = rd_q;
`endif
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_d = WR;
                    if (pending[0]) begin
                        pend_clr  = 3'b001;
                        pat_nxt_d = pat + 8'd1;
                    end else if (pending[1]) begin
                        pend_clr  = 3'b010;
                        pat_nxt_d = pat - 8'd1;
                    end else begin
                        pend_clr  = 3'b100;
                        pat_nxt_d = 8'd0;
                    end
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                    adr_d = TARGET_ADR;
                    dat_d = {24'h0, pat_nxt_d};
                end
            end
            WR: begin
                if (wbm_ack_i) begin
                    pat_d = pat_nxt;
`ifdef WB_INITIATOR_READBACK_EN
                    // cyc stays up; stb drops for one cycle before the read
                    state_d = RD;
                    cyc_d   = 1'b1;
                    sel_d   = 4'hF;
                    adr_d   = TARGET_ADR;
`else
                    state_d = IDLE;
`endif
                end else if (tmo_cnt == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_cnt + 16'd1;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                    adr_d = TARGET_ADR;
                    dat_d = {24'h0, pat_nxt};
                end
            end
`ifdef WB_INITIATOR_READBACK_EN
            RD: begin
                if (!wbm_stb_o) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = 4'hF;
                    adr_d = TARGET_ADR;
                end else if (wbm_ack_i) begin
                    rd_d    = wbm_dat_i;
                    state_d = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_cnt + 16'd1;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = 4'hF;
                    adr_d = TARGET_ADR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            pat       <= '0;
            pat_nxt   <= '0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
`ifdef WB_INITIATOR_READBACK_EN
            rd_q      <= '0;
`endif
        end else begin
            state     <= state_d;
            wbm_cyc_o <= cyc_d;
            wbm_stb_o <= stb_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            pat       <= pat_d;
            pat_nxt   <= pat_nxt_d;
            tmo_cnt   <= tmo_d;
            err       <= err_d;
            busy      <= (state_d != IDLE);
`ifdef WB_INITIATOR_READBACK_EN
            rd_q      <= rd_d;
`endif
        end
    end

    assign dbg_state = state;

endmodule
